// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types for the EX-stage forwarding / hazard logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int TAG_ADDR_W = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [TAG_ADDR_W-1:0] rs1;
        logic [TAG_ADDR_W-1:0] rs2;
        logic [TAG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } stage_tag_t;

    // x0 is hardwired, so a tag targeting it never produces a forwardable value
    function automatic logic tag_writing(input stage_tag_t t);
        return t.valid && t.regwrite && (t.rd != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_sel_calc.sv
// ============================================================================
// Module : fwd_sel_calc
// Brief  : Combinational forwarding select for one EX source operand.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_sel_calc
    import pipe_pkg::*;
(
    input  logic [TAG_ADDR_W-1:0] src,
    input  stage_tag_t            mem_tag,
    input  stage_tag_t            wb_tag,
    output fwd_sel_t              sel
);

    logic w_unused;

    // The younger producer in MEM wins over WB
    always_comb begin
        sel = FWD_REG;
        if (tag_writing(mem_tag) && (mem_tag.rd == src)) begin
            sel = FWD_MEM;
        end else if (tag_writing(wb_tag) && (wb_tag.rd == src)) begin
            sel = FWD_WB;
        end
    end

    assign w_unused = ^{mem_tag.rs1, mem_tag.rs2, mem_tag.memread,
                        wb_tag.rs1, wb_tag.rs2, wb_tag.memread};

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// Module : fwd_hazard_unit
// Brief  : EX operand forwarding selects, load-use stall and stall counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic                  ex_bubble,
    output logic [CNT_W-1:0]      stall_cnt
);

    stage_tag_t       r_ex;
    stage_tag_t       r_mem;
    stage_tag_t       r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    stage_tag_t       w_id_tag;
    logic             w_load_use;
    logic             w_ex_load;
    fwd_sel_t         w_sel_a;
    fwd_sel_t         w_sel_b;

    // Register indices are carried in the package-wide tag width
    assign w_id_tag = '{valid:    id_valid,
                        rs1:      TAG_ADDR_W'(id_rs1),
                        rs2:      TAG_ADDR_W'(id_rs2),
                        rd:       TAG_ADDR_W'(id_rd),
                        regwrite: id_regwrite,
                        memread:  id_memread};

    assign w_load_use = id_valid && r_ex.memread && tag_writing(r_ex) &&
                        ((r_ex.rd == w_id_tag.rs1) || (r_ex.rd == w_id_tag.rs2));

    // A redirect kills the dependent instruction, so there is nothing to stall
    assign stall     = w_load_use && !flush;
    assign ex_bubble = stall || flush;
    assign w_ex_load = id_valid && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_ex_load ? w_id_tag : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    fwd_sel_calc u_fwd_a (
        .src     (r_ex.rs1),
        .mem_tag (r_mem),
        .wb_tag  (r_wb),
        .sel     (w_sel_a)
    );

    fwd_sel_calc u_fwd_b (
        .src     (r_ex.rs2),
        .mem_tag (r_mem),
        .wb_tag  (r_wb),
        .sel     (w_sel_b)
    );

    assign fwd_a     = r_ex.valid ? w_sel_a : FWD_REG;
    assign fwd_b     = r_ex.valid ? w_sel_b : FWD_REG;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
// Module : tb_fwd_hazard_unit
// Brief  : Self-checking bench for fwd_hazard_unit with an in-flight model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic [AW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_memread;
    logic          flush;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          stall;
    logic          ex_bubble;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
        .ex_bubble   (ex_bubble),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: list of instructions in flight, index 0 = EX, 1 = MEM, 2 = WB
    typedef struct packed {
        logic          v;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
    } m_ins_t;

    m_ins_t inflight [3];
    int     m_cnt;

    function automatic logic produces(input m_ins_t i);
        return i.v && i.rw && (i.rd != 0);
    endfunction

    // Nearest older producer of src supplies the operand
    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] src);
        if (!inflight[0].v) return 2'd0;
        for (int k = 1; k <= 2; k++) begin
            if (produces(inflight[k]) && inflight[k].rd == src) return 2'(k);
        end
        return 2'd0;
    endfunction

    function automatic logic exp_stall();
        return !flush && id_valid && produces(inflight[0]) && inflight[0].mr &&
               (inflight[0].rd == id_rs1 || inflight[0].rd == id_rs2);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) inflight[k] = '0;
        m_cnt = 0;
    endtask

    task automatic model_step();
        logic s;
        s = exp_stall();
        if (s && m_cnt < (1 << CW) - 1) m_cnt++;
        inflight[2] = inflight[1];
        inflight[1] = inflight[0];
        if (id_valid && !s && !flush)
            inflight[0] = '{v: 1'b1, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                            rw: id_regwrite, mr: id_memread};
        else
            inflight[0] = '0;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] rd, input logic rw, input logic mr,
                         input logic fl);
        id_valid    = v;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
    endtask

    // Advance one clock, then present the next ID-stage instruction
    task automatic put(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [AW-1:0] rd, input logic rw, input logic mr,
                       input logic fl);
        @(posedge clk);
        model_step();
        @(negedge clk);
        drive(v, r1, r2, rd, rw, mr, fl);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset pulse contained between two rising edges
    task automatic short_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #2;
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a got %b want 00", fwd_a); end
        n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b got %b want 00", fwd_b); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        n_checks++; if (ex_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %b want 0", ex_bubble); end
        n_checks++; if (stall_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        put(1, 1, 2, 5, 1, 0, 0);          // add x5,x1,x2
        put(1, 5, 3, 6, 1, 0, 0);          // sub x6,x5,x3 ; add now in EX
        rst_n = 1'b0;
        #1;
        n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL midreset_fwd got %b/%b want 00/00", fwd_a, fwd_b); end
        n_checks++; if (stall !== 1'b0 || ex_bubble !== 1'b0 || stall_cnt !== 4'h0) begin n_fail++; $display("FAIL midreset_ctl got %b/%b/%h want 0/0/0", stall, ex_bubble, stall_cnt); end
        model_clear();
        rst_n = 1'b1;
        idle(1);                           // sub in EX; add was wiped
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL midreset_stale got %b want 00", fwd_a); end
        idle(3);
    endtask

    task automatic test_alu_back_to_back();
        put(1, 1, 2, 5, 1, 0, 0);          // add x5,x1,x2
        put(1, 5, 3, 6, 1, 0, 0);          // sub x6,x5,x3
        put(1, 1, 5, 7, 1, 0, 0);          // and x7,x1,x5 ; sub in EX
        n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL b2b_mem_a got %b want 01", fwd_a); end
        n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL b2b_mem_b got %b want 00", fwd_b); end
        idle(1);                           // and in EX, add in WB
        n_checks++; if (fwd_b !== 2'b10) begin n_fail++; $display("FAIL b2b_wb_b got %b want 10", fwd_b); end
        n_checks++; if (fwd_a !== 2'b00) begin n_fail++; $display("FAIL b2b_wb_a got %b want 00", fwd_a); end
        idle(3);
    endtask

    task automatic test_double_match();
        put(1, 1, 2, 5, 1, 0, 0);
        put(1, 3, 4, 5, 1, 0, 0);
        put(1, 5, 5, 7, 1, 0, 0);          // or x7,x5,x5
        idle(1);
        n_checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin n_fail++; $display("FAIL double_prio got %b/%b want 01/01", fwd_a, fwd_b); end
        put(1, 1, 2, 0, 1, 0, 0);          // add x0,x1,x2
        put(1, 0, 0, 9, 1, 0, 0);          // reads x0
        idle(1);
        n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL x0_mem got %b/%b want 00/00", fwd_a, fwd_b); end
        idle(3);
    endtask

    task automatic test_load_use();
        put(1, 1, 0, 8, 1, 1, 0);          // lw x8
        put(1, 8, 4, 9, 1, 0, 0);          // add x9,x8,x4 ; lw in EX
        n_checks++; if (stall !== 1'b1 || ex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b/%b want 1/1", stall, ex_bubble); end
        n_checks++; if (stall_cnt !== 4'h0) begin n_fail++; $display("FAIL lu_cnt_pre got %h want 0", stall_cnt); end
        put(1, 8, 4, 9, 1, 0, 0);          // add held in ID
        n_checks++; if (stall !== 1'b0 || ex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b/%b want 0/0", stall, ex_bubble); end
        n_checks++; if (stall_cnt !== 4'h1) begin n_fail++; $display("FAIL lu_cnt got %h want 1", stall_cnt); end
        idle(1);
        n_checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL lu_fwd got %b/%b want 10/00", fwd_a, fwd_b); end
        idle(3);
    endtask

    task automatic test_flush_stall();
        put(1, 1, 0, 8, 1, 1, 0);          // lw x8
        put(1, 8, 1, 9, 1, 0, 1);          // add x9,x8,x1 with flush
        n_checks++; if (stall !== 1'b0 || ex_bubble !== 1'b1) begin n_fail++; $display("FAIL fl_ctl got %b/%b want 0/1", stall, ex_bubble); end
        put(1, 9, 9, 10, 1, 0, 0);         // or x10,x9,x9
        n_checks++; if (stall_cnt !== 4'h1) begin n_fail++; $display("FAIL fl_cnt got %h want 1", stall_cnt); end
        idle(1);
        n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fail++; $display("FAIL fl_fwd got %b/%b want 00/00", fwd_a, fwd_b); end
        idle(3);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            put(1, 1, 0, 8, 1, 1, 0);
            put(1, 8, 4, 9, 1, 0, 0);
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall_%0d got %b want 1", i, stall); end
            put(1, 8, 4, 9, 1, 0, 0);
        end
        idle(1);
        n_checks++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_cnt got %h want f", stall_cnt); end
        idle(3);
    endtask

    task automatic test_random();
        short_reset();
        for (int i = 0; i < 400; i++) begin
            put(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
            n_checks++; if (fwd_a !== exp_fwd(inflight[0].rs1)) begin n_fail++; $display("FAIL rnd_fwd_a cyc %0d got %b want %b", i, fwd_a, exp_fwd(inflight[0].rs1)); end
            n_checks++; if (fwd_b !== exp_fwd(inflight[0].rs2)) begin n_fail++; $display("FAIL rnd_fwd_b cyc %0d got %b want %b", i, fwd_b, exp_fwd(inflight[0].rs2)); end
            n_checks++; if (stall !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %b want %b", i, stall, exp_stall()); end
            n_checks++; if (ex_bubble !== (exp_stall() || flush)) begin n_fail++; $display("FAIL rnd_bubble cyc %0d got %b want %b", i, ex_bubble, exp_stall() || flush); end
            n_checks++; if (stall_cnt !== CW'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %h want %h", i, stall_cnt, CW'(m_cnt)); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_double_match();
        test_load_use();
        test_flush_stall();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
